// File: rtl/me_pkg.sv
// rtl/me_pkg.sv - shared constants and bank bookkeeping types for the ping-pong block store
package me_pkg;

  localparam int ME_DATA_W = 64;
  localparam int ME_REF_AW = 7;
  localparam int ME_CUR_AW = 5;

  localparam int ERR_OVF = 0;
  localparam int ERR_UDF = 1;

  typedef struct packed {
    logic [1:0] full;
    logic       wr_sel;
    logic       rd_sel;
  } bank_state_t;

  function automatic logic [1:0] bank_popcount(input logic [1:0] f);
    return {1'b0, f[0]} + {1'b0, f[1]};
  endfunction

endpackage

// File: rtl/me_pingpong_mem_if.sv
// rtl/me_pingpong_mem_if.sv - loader/engine bus of the ping-pong block store
interface me_pingpong_mem_if #(
  parameter int DATA_W = me_pkg::ME_DATA_W,
  parameter int REF_AW = me_pkg::ME_REF_AW,
  parameter int CUR_AW = me_pkg::ME_CUR_AW
) ();

  logic              write_enable_ref;
  logic [REF_AW-1:0] address_write_ref;
  logic [DATA_W-1:0] data_write_ref;
  logic              write_enable_cur;
  logic [CUR_AW-1:0] address_write_cur;
  logic [DATA_W-1:0] data_write_cur;
  logic              write_commit;
  logic              write_ready;
  logic              read_enable;
  logic [REF_AW-1:0] address_read_ref;
  logic [CUR_AW-1:0] address_read_cur;
  logic [DATA_W-1:0] data_read_ref;
  logic [DATA_W-1:0] data_read_cur;
  logic              read_valid;
  logic              read_release;
  logic              bank_avail;
  logic [1:0]        bank_count;
  logic [1:0]        err;

  modport master (
    output write_enable_ref, address_write_ref, data_write_ref,
    output write_enable_cur, address_write_cur, data_write_cur,
    output write_commit, read_enable, address_read_ref, address_read_cur, read_release,
    input  write_ready, data_read_ref, data_read_cur, read_valid, bank_avail, bank_count, err
  );

  modport slave (
    input  write_enable_ref, address_write_ref, data_write_ref,
    input  write_enable_cur, address_write_cur, data_write_cur,
    input  write_commit, read_enable, address_read_ref, address_read_cur, read_release,
    output write_ready, data_read_ref, data_read_cur, read_valid, bank_avail, bank_count, err
  );

endinterface

// File: rtl/me_sdp_ram.sv
// rtl/me_sdp_ram.sv - simple dual-port RAM, synchronous write, registered read that holds when idle
module me_sdp_ram #(
  parameter int WIDTH = 64,
  parameter int AW    = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [0:(1<<AW)-1];
  logic [WIDTH-1:0] rdata_q, rdata_d;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_comb begin
    rdata_d = rdata_q;
    if (re) rdata_d = mem[raddr];
  end

  // Only the output register is reset so stale array contents never reach the port after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= rdata_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/me_pingpong_mem.sv
// rtl/me_pingpong_mem.sv - two-bank ref/cur block store handed between loader and ME datapath
module me_pingpong_mem import me_pkg::*; #(
  parameter int DATA_W = ME_DATA_W,
  parameter int REF_AW = ME_REF_AW,
  parameter int CUR_AW = ME_CUR_AW
) (
  input logic               clk,
  input logic               reset,
  me_pingpong_mem_if.slave  bus
);

  bank_state_t st_q, st_d;
  logic [1:0]  err_q, err_d;
  logic        read_valid_q, read_valid_d;
  logic        out_sel_q, out_sel_d;

  logic write_ready, bank_avail;
  logic ref_wr_ok, cur_wr_ok, commit_ok, read_ok, release_ok;

  logic [DATA_W-1:0] ref_rdata [2];
  logic [DATA_W-1:0] cur_rdata [2];

  assign write_ready = !st_q.full[st_q.wr_sel];
  assign bank_avail  = st_q.full[st_q.rd_sel];

  assign ref_wr_ok  = bus.write_enable_ref && write_ready;
  assign cur_wr_ok  = bus.write_enable_cur && write_ready;
  assign commit_ok  = bus.write_commit     && write_ready;
  assign read_ok    = bus.read_enable      && bank_avail;
  assign release_ok = bus.read_release     && bank_avail;

  // Commit and release never target the same bank: one needs it empty, the other full.
  always_comb begin
    st_d         = st_q;
    err_d        = err_q;
    read_valid_d = read_ok;
    out_sel_d    = out_sel_q;
    if (commit_ok) begin
      st_d.full[st_q.wr_sel] = 1'b1;
      st_d.wr_sel            = ~st_q.wr_sel;
    end
    if (release_ok) begin
      st_d.full[st_q.rd_sel] = 1'b0;
      st_d.rd_sel            = ~st_q.rd_sel;
    end
    if (read_ok) out_sel_d = st_q.rd_sel;
    if (!write_ready && (bus.write_enable_ref || bus.write_enable_cur || bus.write_commit))
      err_d[ERR_OVF] = 1'b1;
    if (!bank_avail && (bus.read_enable || bus.read_release))
      err_d[ERR_UDF] = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q         <= '0;
      err_q        <= '0;
      read_valid_q <= 1'b0;
      out_sel_q    <= 1'b0;
    end else begin
      st_q         <= st_d;
      err_q        <= err_d;
      read_valid_q <= read_valid_d;
      out_sel_q    <= out_sel_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    me_sdp_ram #(.WIDTH(DATA_W), .AW(REF_AW)) u_ref (
      .clk   (clk),
      .rst_n (reset),
      .we    (ref_wr_ok && (st_q.wr_sel == 1'(b))),
      .waddr (bus.address_write_ref),
      .wdata (bus.data_write_ref),
      .re    (read_ok && (st_q.rd_sel == 1'(b))),
      .raddr (bus.address_read_ref),
      .rdata (ref_rdata[b])
    );
    me_sdp_ram #(.WIDTH(DATA_W), .AW(CUR_AW)) u_cur (
      .clk   (clk),
      .rst_n (reset),
      .we    (cur_wr_ok && (st_q.wr_sel == 1'(b))),
      .waddr (bus.address_write_cur),
      .wdata (bus.data_write_cur),
      .re    (read_ok && (st_q.rd_sel == 1'(b))),
      .raddr (bus.address_read_cur),
      .rdata (cur_rdata[b])
    );
  end

  // The bank that served the last accepted read drives the outputs, so ignored reads hold the data.
  assign bus.data_read_ref = out_sel_q ? ref_rdata[1] : ref_rdata[0];
  assign bus.data_read_cur = out_sel_q ? cur_rdata[1] : cur_rdata[0];
  assign bus.read_valid    = read_valid_q;
  assign bus.write_ready   = write_ready;
  assign bus.bank_avail    = bank_avail;
  assign bus.bank_count    = bank_popcount(st_q.full);
  assign bus.err           = err_q;

endmodule

// File: tb/tb_me_pingpong_mem.sv
// tb/tb_me_pingpong_mem.sv - scoreboard bench for the ping-pong block store
module tb_me_pingpong_mem;
  import me_pkg::*;

  localparam int DW  = 64;
  localparam int RAW = 7;
  localparam int CAW = 5;

  typedef struct {
    logic [DW-1:0] r;
    logic [DW-1:0] c;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  me_pingpong_mem_if #(.DATA_W(DW), .REF_AW(RAW), .CUR_AW(CAW)) bus ();
  me_pingpong_mem #(.DATA_W(DW), .REF_AW(RAW), .CUR_AW(CAW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] m_ref [2][1<<RAW];
  logic [DW-1:0] m_cur [2][1<<CAW];
  int            act_q[$];
  int            fill;
  logic [1:0]    m_err;
  exp_t          sb[$];
  exp_t          mon_e;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.write_enable_ref  = 1'b0;
    bus.address_write_ref = '0;
    bus.data_write_ref    = '0;
    bus.write_enable_cur  = 1'b0;
    bus.address_write_cur = '0;
    bus.data_write_cur    = '0;
    bus.write_commit      = 1'b0;
    bus.read_enable       = 1'b0;
    bus.address_read_ref  = '0;
    bus.address_read_cur  = '0;
    bus.read_release      = 1'b0;
  endtask

  task automatic model_clear();
    act_q.delete();
    sb.delete();
    fill  = 0;
    m_err = 2'b00;
  endtask

  // Model: committed banks form a FIFO; the head is the readable bank, fill alternates.
  task automatic step();
    bit   wr_rdy, avail, do_rd;
    int   act;
    exp_t e;
    wr_rdy = act_q.size() < 2;
    avail  = act_q.size() > 0;
    act    = avail ? act_q[0] : 0;
    do_rd  = bus.read_enable && avail;
    if (do_rd) begin
      e.r = m_ref[act][bus.address_read_ref];
      e.c = m_cur[act][bus.address_read_cur];
    end
    if (!avail && (bus.read_enable || bus.read_release)) m_err[ERR_UDF] = 1'b1;
    if (!wr_rdy && (bus.write_enable_ref || bus.write_enable_cur || bus.write_commit)) m_err[ERR_OVF] = 1'b1;
    if (wr_rdy && bus.write_enable_ref) m_ref[fill][bus.address_write_ref] = bus.data_write_ref;
    if (wr_rdy && bus.write_enable_cur) m_cur[fill][bus.address_write_cur] = bus.data_write_cur;
    if (avail && bus.read_release) void'(act_q.pop_front());
    if (wr_rdy && bus.write_commit) begin
      act_q.push_back(fill);
      fill = 1 - fill;
    end
    @(posedge clk);
    if (do_rd) sb.push_back(e);
    #1;
    check("bank_count", 64'(bus.bank_count), 64'(act_q.size()));
    check("write_ready", 64'(bus.write_ready), 64'(act_q.size() < 2));
    check("bank_avail", 64'(bus.bank_avail), 64'(act_q.size() > 0));
    check("err", 64'(bus.err), 64'(m_err));
    idle_inputs();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    idle_inputs();
    model_clear();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic wr_ref(input logic [RAW-1:0] a, input logic [DW-1:0] d);
    bus.write_enable_ref  = 1'b1;
    bus.address_write_ref = a;
    bus.data_write_ref    = d;
  endtask

  task automatic rd(input logic [RAW-1:0] ar, input logic [CAW-1:0] ac);
    bus.read_enable      = 1'b1;
    bus.address_read_ref = ar;
    bus.address_read_cur = ac;
  endtask

  always @(negedge clk) begin
    if (reset) begin
      if (bus.read_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_spurious actual=1 required=0");
        end else begin
          mon_e = sb.pop_front();
          check("rd_ref", bus.data_read_ref, mon_e.r);
          check("rd_cur", bus.data_read_cur, mon_e.c);
        end
      end else if (sb.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL rd_latency actual=0 required=1");
        void'(sb.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Preload every word of both banks so all later reads have known data.
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < (1 << RAW); i++) begin
        wr_ref(RAW'(i), {$urandom(), $urandom()});
        bus.write_enable_cur  = 1'b1;
        bus.address_write_cur = CAW'(i);
        bus.data_write_cur    = {$urandom(), $urandom()};
        bus.write_commit      = (i == (1 << RAW) - 1);
        step();
      end
    end
    repeat (2) begin bus.read_release = 1'b1; step(); end

    do_reset();
    check("rst_write_ready", 64'(bus.write_ready), 64'd1);
    check("rst_bank_avail", 64'(bus.bank_avail), 64'd0);
    check("rst_bank_count", 64'(bus.bank_count), 64'd0);
    check("rst_err", 64'(bus.err), 64'd0);
    check("rst_read_valid", 64'(bus.read_valid), 64'd0);
    check("rst_data_ref", bus.data_read_ref, 64'd0);

    // Fill, commit, read
    wr_ref(7'h40, 64'h1234);
    bus.write_enable_cur = 1'b1; bus.address_write_cur = 5'h1B; bus.data_write_cur = 64'hC5;
    step();
    bus.write_commit = 1'b1; step();
    check("t1_avail", 64'(bus.bank_avail), 64'd1);
    rd(7'h40, 5'h1B); step();
    check("t1_ref", bus.data_read_ref, 64'h1234);
    check("t1_cur", bus.data_read_cur, 64'hC5);
    step();
    check("t1_valid_once", 64'(bus.read_valid), 64'd0);
    bus.read_release = 1'b1; step();

    // Ping-pong
    wr_ref(0, 64'hA); bus.write_commit = 1'b1; step();
    check("t2_cnt1", 64'(bus.bank_count), 64'd1);
    wr_ref(0, 64'hB); bus.write_commit = 1'b1; step();
    check("t2_cnt2", 64'(bus.bank_count), 64'd2);
    rd(0, 0); step();
    check("t2_first", bus.data_read_ref, 64'hA);
    bus.read_release = 1'b1; step();
    check("t2_cnt3", 64'(bus.bank_count), 64'd1);
    rd(0, 0); step();
    check("t2_second", bus.data_read_ref, 64'hB);
    bus.read_release = 1'b1; step();

    // Overflow
    wr_ref(0, 64'h31); bus.write_commit = 1'b1; step();
    wr_ref(0, 64'h32); bus.write_commit = 1'b1; step();
    wr_ref(0, 64'hFF); bus.write_commit = 1'b1; step();
    check("t3_err", 64'(bus.err), 64'b01);
    check("t3_wr_ready", 64'(bus.write_ready), 64'd0);
    check("t3_cnt", 64'(bus.bank_count), 64'd2);
    bus.read_release = 1'b1; step();
    rd(0, 0); step();
    check("t3_data", bus.data_read_ref, 64'h32);
    bus.read_release = 1'b1; step();

    // Underflow
    do_reset();
    bus.read_enable = 1'b1; bus.read_release = 1'b1; step();
    check("t4_err", 64'(bus.err), 64'b10);
    check("t4_valid", 64'(bus.read_valid), 64'd0);
    check("t4_ref", bus.data_read_ref, 64'd0);
    check("t4_cur", bus.data_read_cur, 64'd0);

    // Simultaneous commit and release
    do_reset();
    wr_ref(0, 64'h55); bus.write_commit = 1'b1; step();
    wr_ref(0, 64'h66); bus.write_commit = 1'b1; bus.read_release = 1'b1; step();
    check("t5_cnt", 64'(bus.bank_count), 64'd1);
    check("t5_err", 64'(bus.err), 64'b00);
    rd(0, 0); step();
    check("t5_data", bus.data_read_ref, 64'h66);

    // Reset mid-read
    rd(0, 0);
    @(posedge clk);
    #1;
    check("t6_pre_valid", 64'(bus.read_valid), 64'd1);
    #1;
    reset = 1'b0;
    #1;
    check("t6_valid", 64'(bus.read_valid), 64'd0);
    check("t6_ref", bus.data_read_ref, 64'd0);
    check("t6_cur", bus.data_read_cur, 64'd0);
    check("t6_cnt", 64'(bus.bank_count), 64'd0);
    do_reset();

    // Randomised traffic against the model
    for (int i = 0; i < 1500; i++) begin
      bus.write_enable_ref  = 1'($urandom_range(0, 1));
      bus.address_write_ref = RAW'($urandom());
      bus.data_write_ref    = {$urandom(), $urandom()};
      bus.write_enable_cur  = 1'($urandom_range(0, 1));
      bus.address_write_cur = CAW'($urandom());
      bus.data_write_cur    = {$urandom(), $urandom()};
      bus.write_commit      = ($urandom_range(0, 11) == 0);
      bus.read_enable       = ($urandom_range(0, 2) == 0);
      bus.address_read_ref  = RAW'($urandom());
      bus.address_read_cur  = CAW'($urandom());
      bus.read_release      = ($urandom_range(0, 11) == 0);
      step();
      if (i % 500 == 499) do_reset();
    end

    @(negedge clk);
    #1;
    check("sb_drain", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
